// File: rtl/lcd_text_arbiter_pkg.sv
// Shared types and constants for the LCD text arbiter.
//   arb_state_t     : arbiter FSM states
//   LCD_TEXT_BYTES  : characters per frame, two '\n' line markers included
//   FREQ_HZ         : system clock frequency; one second of cycles
//   onehot_to_idx   : index of the set bit of a one-hot vector (up to 8 bits)
package lcd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    GAP
  } arb_state_t;

  localparam int unsigned LCD_TEXT_BYTES = 34;
  localparam int unsigned FREQ_HZ        = 50_000_000;

  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/lcd_text_arbiter_if.sv
// Bundle between the request sources / LCD writer and the arbiter.
//   req      : per-requester level request, held until its ack
//   text_in  : packed frames, requester i at [i*TEXT_BYTES*8 +: TEXT_BYTES*8]
//   lcd_done : writer completion pulse
//   lcd_send : one-cycle writer start pulse
//   lcd_text : latched frame of the current owner
//   gnt      : one-hot owner, zero when idle
//   ack      : one-cycle completion pulse to the owner
//   err      : set with ack when the transfer timed out
//   busy     : arbiter not idle
// master = request sources and writer side, slave = arbiter side.
interface lcd_arb_if import lcd_arb_pkg::*; #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned TEXT_BYTES = LCD_TEXT_BYTES
);

  logic [N_REQ-1:0]              req;
  logic [N_REQ*TEXT_BYTES*8-1:0] text_in;
  logic                          lcd_done;
  logic                          lcd_send;
  logic [TEXT_BYTES*8-1:0]       lcd_text;
  logic [N_REQ-1:0]              gnt;
  logic [N_REQ-1:0]              ack;
  logic                          err;
  logic                          busy;

  modport master (
    output req, text_in, lcd_done,
    input  lcd_send, lcd_text, gnt, ack, err, busy
  );

  modport slave (
    input  req, text_in, lcd_done,
    output lcd_send, lcd_text, gnt, ack, err, busy
  );

endinterface

// File: rtl/lcd_text_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : highest-priority index this round
//   win : one-hot winner, first set request at or above ptr, wrapping
//   any : at least one request present
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned PW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] win,
  output logic             any
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = PW'((32'(ptr) + k) % N_REQ);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/lcd_text_arbiter.sv
// Shares one LCD text writer between N_REQ requesters.
// Picks a requester round-robin, latches its frame, pulses lcd_send, then waits
// for lcd_done or a timeout, acknowledges the owner and holds off for GAP_CYC
// cycles before the next grant. All outputs are registered.
//   CLK     : system clock
//   reset_n : synchronous active-low reset
//   bus     : lcd_arb_if slave (requests, frames, writer handshake, status)
module lcd_text_arbiter import lcd_arb_pkg::*; #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned TEXT_BYTES  = LCD_TEXT_BYTES,
  parameter int unsigned TIMEOUT_CYC = FREQ_HZ,
  parameter int unsigned GAP_CYC     = 1000
) (
  input logic   CLK,
  input logic   reset_n,
  lcd_arb_if.slave bus
);

  localparam int unsigned FW = TEXT_BYTES * 8;
  localparam int unsigned PW = $clog2(N_REQ);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  localparam int unsigned GW = $clog2(GAP_CYC + 1);

  arb_state_t       state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             err_q, err_d;
  logic             send_q, send_d;
  logic             busy_q, busy_d;
  logic [FW-1:0]    text_q, text_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [GW-1:0]    gap_q, gap_d;

  logic [N_REQ-1:0] win;
  logic             any_req;

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req(bus.req),
    .ptr(ptr_q),
    .win(win),
    .any(any_req)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    err_d   = 1'b0;
    send_d  = 1'b0;
    text_d  = text_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = PW'(onehot_to_idx(8'(win)));
          gnt_d   = win;
          send_d  = 1'b1;
          state_d = SEND;
          for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win[i]) text_d = bus.text_in[i*FW +: FW];
          end
        end
      end
      SEND: begin
        // lcd_done in this cycle belongs to no transfer of ours
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Completion wins over a coinciding timeout
        if (bus.lcd_done || (tmo_q == TW'(TIMEOUT_CYC - 1))) begin
          ack_d   = gnt_q;
          err_d   = !bus.lcd_done;
          gnt_d   = '0;
          ptr_d   = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
          gap_d   = '0;
          state_d = GAP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYC - 1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      send_q  <= 1'b0;
      busy_q  <= 1'b0;
      text_q  <= '0;
      tmo_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      send_q  <= send_d;
      busy_q  <= busy_d;
      text_q  <= text_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
    end
  end

  assign bus.lcd_send = send_q;
  assign bus.lcd_text = text_q;
  assign bus.gnt      = gnt_q;
  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_lcd_text_arbiter.sv
// Scoreboard bench for lcd_text_arbiter: the driver derives expected grants and
// acknowledges from a transaction-level model and queues them; a monitor pops
// and compares whenever the DUT pulses lcd_send or ack.
module tb_lcd_text_arbiter;
  import lcd_arb_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned TB = LCD_TEXT_BYTES;
  localparam int unsigned FW = TB * 8;
  localparam int          TO = 100;
  localparam int          GC = 6;
  localparam int M_DONE = 0, M_TIMEOUT = 1, M_SEND_DONE = 2;

  typedef struct {
    logic [NR-1:0] gnt;
    logic [FW-1:0] frame;
    int            cyc;
  } send_t;

  typedef struct {
    logic [NR-1:0] ack;
    logic          err;
    int            cyc;
  } ack_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_arb_if #(.N_REQ(NR), .TEXT_BYTES(TB)) bus ();

  lcd_text_arbiter #(
    .N_REQ(NR),
    .TEXT_BYTES(TB),
    .TIMEOUT_CYC(TO),
    .GAP_CYC(GC)
  ) dut (
    .CLK(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  send_t exp_send[$];
  ack_t  exp_ack[$];
  int    n_pass = 0;
  int    n_total = 0;
  bit    inv_bad = 1'b0;
  bit    mon_en = 1'b0;

  // Transaction-level model state
  logic [NR-1:0] req_mask;
  logic [FW-1:0] frames[NR];
  int            ptr_m;
  int            idle_from;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  function automatic logic [FW-1:0] gen_frame(input bit abc);
    logic [FW-1:0] f;
    logic [7:0]    ch;
    f = '0;
    for (int b = 0; b < int'(TB); b++) begin
      if (b == 0 || b == 17) ch = 8'h0a;
      else if (abc) ch = 8'h61 + 8'(b % 26);
      else ch = 8'h61 + 8'($urandom_range(0, 25));
      f[(int'(TB) - 1 - b) * 8 +: 8] = ch;
    end
    return f;
  endfunction

  function automatic logic [NR-1:0] onehot(input int w);
    logic [NR-1:0] v;
    v = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  // First requester at or above the pointer, counting round the ring
  function automatic int pick(input logic [NR-1:0] m, input int p);
    for (int k = 0; k < int'(NR); k++) begin
      if (m[(p + k) % int'(NR)]) return (p + k) % int'(NR);
    end
    return -1;
  endfunction

  task automatic drive_bus();
    logic [NR*FW-1:0] t;
    t = '0;
    for (int i = 0; i < int'(NR); i++) t[i*FW +: FW] = frames[i];
    bus.req     = req_mask;
    bus.text_in = t;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, FW'(bus.gnt), '0);
    chk({tag, "_ack"}, FW'(bus.ack), '0);
    chk({tag, "_err"}, FW'(bus.err), '0);
    chk({tag, "_send"}, FW'(bus.lcd_send), '0);
    chk({tag, "_busy"}, FW'(bus.busy), '0);
    chk({tag, "_text"}, bus.lcd_text, '0);
  endtask

  // One transfer; called at a negedge while the DUT is in GAP or IDLE.
  task automatic run_transfer(input logic [NR-1:0] add, input int idle_wait, input int mode,
                              input int d, input bit keep, input bit mutate, input bit drop,
                              input bit do_reset, input bit abc);
    int e, a, w;
    bit done_ok;
    if (idle_wait > 0 && req_mask == '0) wait_until(idle_from + idle_wait);
    for (int i = 0; i < int'(NR); i++) begin
      if (add[i] && !req_mask[i]) frames[i] = gen_frame(abc);
    end
    req_mask = req_mask | add;
    drive_bus();
    if (req_mask == '0) return;
    e = (cyc + 1 > idle_from + 1) ? cyc + 1 : idle_from + 1;
    w = pick(req_mask, ptr_m);
    exp_send.push_back('{gnt: onehot(w), frame: frames[w], cyc: e});
    wait_until(e);
    if (mode == M_SEND_DONE) begin
      bus.lcd_done = 1'b1;
      @(negedge clk);
      bus.lcd_done = 1'b0;
    end
    if (mutate) begin
      wait_until(e + 1);
      frames[w] = gen_frame(1'b0);
      drive_bus();
    end
    if (drop) begin
      wait_until(e + 1);
      req_mask[w] = 1'b0;
      drive_bus();
    end
    if (do_reset) begin
      wait_until(e + 3);
      reset_n  = 1'b0;
      req_mask = '0;
      drive_bus();
      @(negedge clk);
      reset_n = 1'b1;
      check_all_zero("midrst");
      bus.lcd_done = 1'b1;
      @(negedge clk);
      bus.lcd_done = 1'b0;
      ptr_m     = 0;
      idle_from = e + 4;
      return;
    end
    done_ok = (mode != M_TIMEOUT) && (d < TO);
    a = done_ok ? e + 2 + d : e + 1 + TO;
    exp_ack.push_back('{ack: onehot(w), err: !done_ok, cyc: a});
    if (done_ok) begin
      wait_until(e + 1 + d);
      bus.lcd_done = 1'b1;
      @(negedge clk);
      bus.lcd_done = 1'b0;
    end
    wait_until(a);
    ptr_m = (w + 1) % int'(NR);
    if (!keep) req_mask[w] = 1'b0;
    drive_bus();
    idle_from = a + GC;
  endtask

  // Monitor
  logic [FW-1:0] cur_frame;
  bit tracking = 1'b0;
  bit text_bad = 1'b0;

  initial begin
    send_t s;
    ack_t  k;
    cur_frame = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if ($countones(bus.gnt) > 1) inv_bad = 1'b1;
        if (bus.err === 1'b1 && bus.ack == '0) inv_bad = 1'b1;
        if (tracking && bus.gnt != '0 && bus.lcd_text !== cur_frame) text_bad = 1'b1;
        if (bus.lcd_send === 1'b1) begin
          if (exp_send.size() == 0) begin
            n_total++;
            $display("FAIL send_unexpected: lcd_send at cycle %0d, none due", cyc);
          end else begin
            s = exp_send.pop_front();
            chk("send_cycle", FW'(cyc), FW'(s.cyc));
            chk("send_gnt", FW'(bus.gnt), FW'(s.gnt));
            chk("send_text", bus.lcd_text, s.frame);
            chk("send_busy", FW'(bus.busy), FW'(1'b1));
            cur_frame = s.frame;
            tracking  = 1'b1;
            text_bad  = 1'b0;
          end
        end
        if (bus.ack != '0) begin
          if (exp_ack.size() == 0) begin
            n_total++;
            $display("FAIL ack_unexpected: ack %0h at cycle %0d, none due", bus.ack, cyc);
          end else begin
            k = exp_ack.pop_front();
            chk("ack_cycle", FW'(cyc), FW'(k.cyc));
            chk("ack_value", FW'(bus.ack), FW'(k.ack));
            chk("ack_err", FW'(bus.err), FW'(k.err));
            chk("ack_gnt_clear", FW'(bus.gnt), '0);
            chk("text_stable", FW'(text_bad), '0);
            tracking = 1'b0;
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    int d, md;
    logic [NR-1:0] add;
    bus.req      = '0;
    bus.text_in  = '0;
    bus.lcd_done = 1'b0;
    req_mask     = '0;
    ptr_m        = 0;
    for (int i = 0; i < int'(NR); i++) frames[i] = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check_all_zero("reset");
    idle_from = cyc;
    mon_en    = 1'b1;

    // Single request with a fixed "\nabc..." frame, then busy drops after the gap
    run_transfer(4'b0001, 0, M_DONE, 50, 0, 0, 0, 0, 1);
    wait_until(idle_from - 1);
    chk("busy_in_gap", FW'(bus.busy), FW'(1'b1));
    wait_until(idle_from);
    chk("busy_after_gap", FW'(bus.busy), '0);

    // Rotation with all four held
    run_transfer(4'b1111, 0, M_DONE, $urandom_range(0, 60), 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) run_transfer('0, 0, M_DONE, $urandom_range(0, 60), 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) run_transfer('0, 0, M_DONE, $urandom_range(0, 60), 0, 0, 0, 0, 0);

    // Timeout, request arriving while idle
    run_transfer(4'b0100, 3, M_TIMEOUT, 0, 0, 0, 0, 0, 0);
    // Completion on the timeout cycle
    run_transfer(4'b0001, 0, M_DONE, TO - 1, 0, 0, 0, 0, 0);
    // Done during SEND ignored
    run_transfer(4'b0010, 0, M_SEND_DONE, 20, 0, 0, 0, 0, 0);
    // Owner frame changes during WAIT
    run_transfer(4'b1000, 0, M_DONE, 30, 0, 1, 0, 0, 0);
    // Owner drops req during WAIT
    run_transfer(4'b0001, 0, M_DONE, 10, 0, 0, 1, 0, 0);

    // Randomised traffic
    for (int n = 0; n < 20; n++) begin
      add = NR'($urandom_range(0, 15));
      if ((req_mask | add) == '0) add = onehot($urandom_range(0, NR - 1));
      md = $urandom_range(0, 2);
      d  = $urandom_range(0, TO + 20);
      run_transfer(add, $urandom_range(0, 4), md, d, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
    end
    while (req_mask != '0) run_transfer('0, 0, M_DONE, $urandom_range(0, 40), 0, 0, 0, 0, 0);

    // Leave the pointer at 2, abort the next transfer by reset, then 1010 must go to 1
    run_transfer(4'b0010, 0, M_DONE, 5, 0, 0, 0, 0, 0);
    run_transfer(4'b0100, 0, M_DONE, 50, 0, 0, 0, 1, 0);
    run_transfer(4'b1010, 2, M_DONE, 5, 0, 0, 0, 0, 0);
    while (req_mask != '0) run_transfer('0, 0, M_DONE, 5, 0, 0, 0, 0, 0);

    repeat (GC + 10) @(negedge clk);
    chk("send_queue_drained", FW'(exp_send.size()), '0);
    chk("ack_queue_drained", FW'(exp_ack.size()), '0);
    chk("invariants", FW'(inv_bad), '0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
